// File: rtl/analog_status_capture.sv
// Synchronises and debounces raw analog status bits into level, sticky rise/fall and transition-count words.
// Define ANALOG_STATUS_IRQ_EN to add a registered irq output that is high while any sticky flag is set.
module analog_status_capture #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [31:0]      clear_rise,
    input  logic [31:0]      clear_fall,
    input  logic             count_clear,
    output logic [31:0]      status_0,
    output logic [31:0]      status_1,
    output logic [31:0]      status_2,
`ifdef ANALOG_STATUS_IRQ_EN
    output logic             irq,
`endif
    output logic [31:0]      status_3
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q,  rise_d;
    logic [WIDTH-1:0] fall_q,  fall_d;
    logic [CNT_W-1:0] dcnt_q [WIDTH];
    logic [CNT_W-1:0] dcnt_d [WIDTH];
    logic [15:0]      count_q, count_d;
    logic [7:0]       idx_q,   idx_d;
    logic [WIDTH-1:0] chg;
    logic             any_chg;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        level_d = level_q;
        chg     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dcnt_d[i] = '0;
            // Any sample agreeing with the current level restarts the run.
            if (sync2_q[i] != level_q[i]) begin
                if (dcnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                    chg[i]     = 1'b1;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign any_chg = |chg;

    always_comb begin
        // A new edge outranks a clear arriving on the same cycle.
        rise_d = (rise_q & ~clear_rise[WIDTH-1:0]) | (chg & level_d);
        fall_d = (fall_q & ~clear_fall[WIDTH-1:0]) | (chg & ~level_d);
    end

    always_comb begin
        count_d = count_q;
        if (count_clear) begin
            count_d = {15'b0, any_chg};
        end else if (any_chg && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_comb begin
        idx_d = idx_q;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (chg[i]) begin
                idx_d = 8'(i);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            for (int i = 0; i < WIDTH; i++) begin
                dcnt_q[i] <= dcnt_d[i];
            end
        end
    end

`ifdef ANALOG_STATUS_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = |{rise_d, fall_d};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        status_0 = '0;
        status_1 = '0;
        status_2 = '0;
        status_0[WIDTH-1:0] = level_q;
        status_1[WIDTH-1:0] = rise_q;
        status_2[WIDTH-1:0] = fall_q;
        status_3 = {count_q, 8'h00, idx_q};
    end

endmodule

// File: tb/tb_analog_status_capture.sv
// Bench for analog_status_capture: a D=4 full-width instance and a D=1, 8-bit instance used for counter saturation.
module tb_analog_status_capture;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [31:0] raw1, cr1, cf1;
    logic        cc1;
    logic [7:0]  raw2;
    logic [31:0] cr2, cf2;
    logic        cc2;
    logic [31:0] s0_1, s1_1, s2_1, s3_1;
    logic [31:0] s0_2, s1_2, s2_2, s3_2;
`ifdef ANALOG_STATUS_IRQ_EN
    logic        irq1, irq2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    analog_status_capture #(.WIDTH(32), .DEBOUNCE_CYCLES(4)) u_main (
        .clk_in(clk_in), .reset(reset), .raw_in(raw1),
        .clear_rise(cr1), .clear_fall(cf1), .count_clear(cc1),
        .status_0(s0_1), .status_1(s1_1), .status_2(s2_1),
`ifdef ANALOG_STATUS_IRQ_EN
        .irq(irq1),
`endif
        .status_3(s3_1)
    );

    analog_status_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) u_sat (
        .clk_in(clk_in), .reset(reset), .raw_in(raw2),
        .clear_rise(cr2), .clear_fall(cf2), .count_clear(cc2),
        .status_0(s0_2), .status_1(s1_2), .status_2(s2_2),
`ifdef ANALOG_STATUS_IRQ_EN
        .irq(irq2),
`endif
        .status_3(s3_2)
    );

    // Model: a bit's level flips once its last D synchronised samples all disagree with it.
    typedef struct packed {
        logic [7:0][31:0] hist;
        logic [31:0]      level;
        logic [31:0]      rise;
        logic [31:0]      fall;
        logic [15:0]      count;
        logic [7:0]       idx;
        logic             irq;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t mdl_step(input mdl_t s, input logic [31:0] raw,
                                      input logic [31:0] cr, input logic [31:0] cf,
                                      input logic cc, input int d, input int w);
        mdl_t        n;
        logic [31:0] msk;
        logic [31:0] flip;
        n    = s;
        msk  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        for (int k = 7; k > 0; k--) n.hist[k] = s.hist[k-1];
        n.hist[0] = raw & msk;
        flip = msk;
        for (int j = 0; j < d; j++) flip = flip & (n.hist[2+j] ^ s.level);
        n.level = s.level ^ flip;
        n.rise  = (s.rise & ~(cr & msk)) | (flip & n.level);
        n.fall  = (s.fall & ~(cf & msk)) | (flip & ~n.level);
        if (cc) n.count = (flip != 0) ? 16'd1 : 16'd0;
        else if (flip != 0 && s.count != 16'hFFFF) n.count = s.count + 16'd1;
        for (int k = 0; k < 32; k++) begin
            if (flip[k]) begin
                n.idx = 8'(k);
                break;
            end
        end
        n.irq = |(n.rise | n.fall);
        return n;
    endfunction

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            m1 = '0;
            m2 = '0;
        end else begin
            m1 = mdl_step(m1, raw1, cr1, cf1, cc1, 4, 32);
            m2 = mdl_step(m2, {24'b0, raw2}, cr2, cf2, cc2, 1, 8);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%08h want=%08h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        chk("main_s0", s0_1, m1.level);
        chk("main_s1", s1_1, m1.rise);
        chk("main_s2", s2_1, m1.fall);
        chk("main_s3", s3_1, {m1.count, 8'h00, m1.idx});
        chk("sat_s0", s0_2, m2.level);
        chk("sat_s1", s1_2, m2.rise);
        chk("sat_s2", s2_2, m2.fall);
        chk("sat_s3", s3_2, {m2.count, 8'h00, m2.idx});
`ifdef ANALOG_STATUS_IRQ_EN
        chk("main_irq", {31'b0, irq1}, {31'b0, m1.irq});
        chk("sat_irq", {31'b0, irq2}, {31'b0, m2.irq});
`endif
    end

    function automatic logic [31:0] dut_word(input int sel);
        case (sel)
            0:       return s0_1;
            1:       return s1_1;
            2:       return s2_1;
            default: return s3_1;
        endcase
    endfunction

    function automatic logic [31:0] mdl_word(input int sel);
        case (sel)
            0:       return m1.level;
            1:       return m1.rise;
            2:       return m1.fall;
            default: return {m1.count, 8'h00, m1.idx};
        endcase
    endfunction

    // Literal expectations applied to both the main instance and its model.
    task automatic pin(input string nm, input int sel, input logic [31:0] exp);
        chk(nm, dut_word(sel), exp);
        chk({"model_", nm}, mdl_word(sel), exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        raw1 = '0; cr1 = '0; cf1 = '0; cc1 = 1'b0;
        raw2 = '0; cr2 = '0; cf2 = '0; cc2 = 1'b0;
        reset = 1'b0;
        m1 = '0;
        m2 = '0;
        #1 reset = 1'b1;
        tick(3);
        pin("rst_s0", 0, 32'h0);
        pin("rst_s3", 3, 32'h0);
        reset = 1'b0;
        tick(2);
        pin("idle_s0", 0, 32'h0);
        pin("idle_s1", 1, 32'h0);

        // Step response: accepted on the sixth edge, not before.
        raw1 = 32'h1;
        tick(5);
        pin("step_early_s0", 0, 32'h0);
        pin("step_early_s3", 3, 32'h0);
        tick(1);
        pin("step_s0", 0, 32'h1);
        pin("step_s1", 1, 32'h1);
        pin("step_s3", 3, 32'h0001_0000);

        // Three-cycle glitch on bit 5 is rejected.
        raw1 = 32'h21;
        tick(3);
        raw1 = 32'h1;
        tick(8);
        pin("glitch_s0", 0, 32'h1);
        pin("glitch_s3", 3, 32'h0001_0000);
        cc1 = 1'b1;
        tick(1);
        cc1 = 1'b0;
        pin("cclr_s3", 3, 32'h0);

        // Four-cycle pulse on bit 5 is accepted, then released.
        raw1 = 32'h21;
        tick(4);
        raw1 = 32'h1;
        tick(2);
        pin("pulse_s0", 0, 32'h21);
        tick(6);
        pin("pulse_end_s0", 0, 32'h1);
        pin("pulse_s1", 1, 32'h21);
        pin("pulse_s2", 2, 32'h20);
        pin("pulse_s3", 3, 32'h0002_0005);

        // Bits 4 and 8 rise together.
        raw1 = 32'h111;
        tick(5);
        pin("simul_early_s0", 0, 32'h1);
        tick(1);
        pin("simul_s0", 0, 32'h111);
        pin("simul_s1", 1, 32'h131);
        pin("simul_s3", 3, 32'h0003_0004);

        // Clear-versus-set priority on bit 0.
        raw1 = 32'h110;
        tick(8);
        pin("fall0_s0", 0, 32'h110);
        pin("fall0_s2", 2, 32'h21);
        pin("fall0_s3", 3, 32'h0004_0000);
        raw1 = 32'h111;
        tick(5);
        cr1 = 32'h1;
        tick(1);
        cr1 = 32'h0;
        pin("setwins_s1", 1, 32'h131);
        pin("setwins_s3", 3, 32'h0005_0000);
        tick(1);
        cr1 = 32'h1;
        cf1 = 32'h2;
        tick(1);
        cr1 = 32'h0;
        cf1 = 32'h0;
        pin("quietclr_s1", 1, 32'h130);
        pin("quietclr_s2", 2, 32'h21);

        // count_clear coincident with a change, then alone.
        raw1 = 32'h110;
        tick(5);
        cc1 = 1'b1;
        tick(1);
        cc1 = 1'b0;
        pin("cclr_chg_s3", 3, 32'h0001_0000);
        raw1 = 32'h100;
        tick(8);
        pin("fall4_s3", 3, 32'h0002_0004);
        cc1 = 1'b1;
        tick(1);
        cc1 = 1'b0;
        pin("cclr_alone_s3", 3, 32'h0000_0004);

        // Reset while bit 3 is part-way through its debounce run.
        raw1 = 32'h108;
        repeat (4) @(posedge clk_in);
        #2 reset = 1'b1;
        #1;
        pin("midrst_s0", 0, 32'h0);
        pin("midrst_s1", 1, 32'h0);
        pin("midrst_s2", 2, 32'h0);
        pin("midrst_s3", 3, 32'h0);
        raw1 = 32'h8;
        tick(2);
        reset = 1'b0;
        tick(5);
        pin("rerise_early_s1", 1, 32'h0);
        tick(1);
        pin("rerise_s0", 0, 32'h8);
        pin("rerise_s1", 1, 32'h8);
        pin("rerise_s3", 3, 32'h0001_0003);
`ifdef ANALOG_STATUS_IRQ_EN
        chk("irq_set", {31'b0, irq1}, 32'h1);
`endif
        cr1 = 32'h8;
        tick(1);
        cr1 = 32'h0;
        pin("irqclr_s1", 1, 32'h0);
`ifdef ANALOG_STATUS_IRQ_EN
        chk("irq_clr", {31'b0, irq1}, 32'h0);
`endif

        // Saturation on the D=1 instance; clear bits above WIDTH are ignored.
        cr2 = 32'hFFFF_FF00;
        cf2 = 32'hFFFF_FF00;
        for (int k = 0; k < 65600; k++) begin
            raw2 = raw2 ^ 8'h04;
            tick(1);
        end
        chk("sat_count", s3_2, 32'hFFFF_0002);
        chk("sat_s1_upper", s1_2, 32'h0000_0004);
        chk("sat_s2_upper", s2_2, 32'h0000_0004);
        raw2 = raw2 ^ 8'h04;
        cc2 = 1'b1;
        tick(1);
        cc2 = 1'b0;
        chk("sat_cclr_chg", s3_2, 32'h0001_0002);
        tick(4);
        cc2 = 1'b1;
        tick(1);
        cc2 = 1'b0;
        chk("sat_cclr_alone", s3_2, 32'h0000_0002);

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/analog_status_capture.md
Name: analog_status_capture

Overview:
- Upstream feeder for the analog status register block.
- Takes raw, asynchronous status bits from the analog macro and puts each bit through a 2-flop synchroniser and a per-bit debounce filter.
- Produces four 32-bit status words: debounced level, sticky rise flags, sticky fall flags, and a transition counter with last-changed index. These drive status_0..status_3 of the APB-readable status array.
- Single clock domain (clk_in); raw inputs are the only asynchronous signals.

Parameters:
- WIDTH, 32, number of raw status bits (1..32); unused upper status bits read 0.
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new value must hold before it is accepted (>=1).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter (derived, not overridden).

Ports:
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- raw_in  input  WIDTH  raw analog status bits, asynchronous to clk_in
- clear_rise  input  32  per-bit single-cycle clear of sticky rise flags
- clear_fall  input  32  per-bit single-cycle clear of sticky fall flags
- count_clear  input  1  single-cycle clear of the transition counter
- status_0  output  32  debounced level
- status_1  output  32  sticky rise flags
- status_2  output  32  sticky fall flags
- status_3  output  32  [31:16] transition count, [15:8] zero, [7:0] index of last changed bit

Behaviour:
- Clock and reset:
  - One clock, clk_in; reset is asynchronous and active-high.
  - While reset is high, all sync flops, debounce counters, levels, flags, the counter and the index are 0, so all outputs are 0.
  - Reset asserted mid-operation clears everything immediately.
  - After release, a raw bit held at 1 is treated as a fresh 0->1 edge: level rises and the rise flag sets D+2 edges later.
- Synchroniser: sync1[i] <= raw_in[i]; sync2[i] <= sync1[i].
- Debounce, per bit, D = DEBOUNCE_CYCLES:
  - If sync2[i] == level[i]: cnt[i] <= 0.
  - Else if cnt[i] == D-1: level[i] <= sync2[i], cnt[i] <= 0, and a change event is flagged.
  - Else: cnt[i] <= cnt[i]+1.
- Latency: a raw change first sampled at edge 1 appears on status_0 at edge D+2. With D=4 that is edge 6; with D=1 it is edge 3.
- Glitch filtering: a sync2 pulse shorter than D cycles produces no change. Any return to the level restarts the count.
- Sticky flags:
  - A 0->1 level change sets rise[i]; a 1->0 change sets fall[i], on the same edge as the level update.
  - clear_rise[i] / clear_fall[i] high for one cycle clears the flag at the next edge.
  - Set and clear on the same edge: set wins, flag stays 1.
  - Clear of an already-zero flag has no effect.
- Transition counter:
  - Increments by exactly 1 on any edge where at least one bit changes, however many bits change.
  - Saturates at 0xFFFF and does not wrap.
  - count_clear sets it to 0. If count_clear coincides with a change, the result is 1.
- Last index:
  - On an edge with changes, idx <= lowest-numbered changing bit.
  - Otherwise held. count_clear does not affect idx.
- Output mapping:
  - All outputs are registered; there is no combinational path from raw_in to any output.
  - status_0[WIDTH-1:0] = level.
  - status_1 = rise; status_2 = fall.
  - status_3 = {count, 8'h00, idx}.
  - Bits at or above WIDTH are 0 in status_0..2. clear bits at or above WIDTH are ignored.

Optional Feature:
- Macro: ANALOG_STATUS_IRQ_EN.
- Defined: adds output port irq (1 bit).
  - Registered irq <= |(rise | fall), using next-state flag values, so irq rises on the same edge as the flag.
  - irq deasserts on the edge where the last flag is cleared.
  - Reset value 0.
- Undefined: no irq port and no extra logic; all other behaviour is identical.

Test Plan:
- Reset / step response: reset high 3 cycles, release, raw_in=0 -> all outputs 0. Then raw_in[0]=1 sampled at edge 1, D=4 -> status_0=0x1, status_1=0x1, status_3=0x0001_0000 at edge 6, not before.
- Glitch rejection: raw_in[5] high for 3 synchronised cycles, D=4 -> no change on any output. A 4-cycle pulse -> status_0[5]=1, then after release status_2[5]=1 and count=2.
- Simultaneous changes: raw_in 0x0 -> 0x0000_0110 in one cycle -> status_0=0x110, status_1=0x110, count increments by 1, status_3[7:0]=0x04.
- Clear priority: clear_rise=0x1 on the same edge bit 0 rises again -> status_1[0] stays 1. A clear pulse on a quiet cycle -> status_1[0]=0 next edge.
- Counter saturation and clear: force 0x10000 change events -> count holds 0xFFFF. count_clear coincident with a change -> count=1. count_clear alone -> count=0, idx unchanged.
- Reset mid-debounce and irq: assert reset while cnt[3]=2 -> all outputs 0 immediately. After release, raw_in[3] held 1 -> rise at edge D+2. With ANALOG_STATUS_IRQ_EN, irq=1 on the same edge and 0 the edge after clear_rise=0x8.
